// File: rtl/fifo_arb_pkg.sv
// Shared types, width helpers and index conversion for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Largest supported requester count; bounds the one-hot helper below.
    localparam int MAX_NUM_REQ = 8;
    localparam int IDX_W       = $clog2(MAX_NUM_REQ);

    // Beat counter must hold 0..MAX_BURST-1 and stay valid for MAX_BURST=1.
    function automatic int beat_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // Round-robin pointer addresses 0..NUM_REQ-1.
    function automatic int ptr_width(input int num_req);
        return $clog2(num_req);
    endfunction

    // Index of the set bit in a one-hot vector; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first asserted req at or after rr_ptr wins.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_valid
);

    // Walk the requesters from rr_ptr, wrapping modulo NUM_REQ (need not be a power of two).
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        winner    = '0;
        any_valid = |req;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                         w_clk,
    input  logic                         wrst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         full,
    input  logic                         write_error,
    output logic                         w_en,
    output logic [DATA_SIZE-1:0]         data_in,
    output logic                         busy,
    output logic [ERR_CNT_W-1:0]         err_count
);

    localparam int BEAT_W = beat_width(MAX_BURST);
    localparam int PTR_W  = ptr_width(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [NUM_REQ-1:0]  winner;
    logic                any_valid;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                granted_req;
    logic                accept;
    logic                burst_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign busy        = (state == BURST);
    assign gnt_idx     = onehot_to_idx(MAX_NUM_REQ'(gnt));
    assign granted_req = |(gnt & req);
    // A full FIFO blocks the accept outright, so w_en can never fire while full.
    assign accept      = busy & granted_req & ~full;
    assign w_en        = accept;
    assign ack         = busy ? (gnt & req & {NUM_REQ{~full}}) : '0;
    assign data_in     = req_data[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE];
    // Burst ends on its last beat, or as soon as the owner drops req (forfeit).
    assign burst_end   = busy & ((accept && (beat == BEAT_W'(MAX_BURST - 1))) || !granted_req);

    // Next-state, grant, beat and pointer decisions.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        beat_nxt   = beat;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    gnt_nxt   = winner;
                    beat_nxt  = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (burst_end) begin
                    gnt_nxt    = '0;
                    beat_nxt   = '0;
                    rr_ptr_nxt = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
                    state_nxt  = IDLE;
                end else if (accept) begin
                    beat_nxt = beat + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = '0;
                beat_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant, beat and rotation pointer registers.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            beat   <= '0;
            rr_ptr <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            beat   <= beat_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Saturating count of cycles with write_error asserted.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            err_count <= '0;
        end else if (write_error && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: transaction-level model plus directed scenarios.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int EW = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic              w_clk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic              full = 1'b0;
    logic              write_error = 1'b0;
    logic              w_en;
    logic [DW-1:0]     data_in;
    logic              busy;
    logic [EW-1:0]     err_count;

    int vectors = 0;
    int miscompares = 0;

    // Model state: who owns the port, words taken in this burst, where the search starts.
    bit m_busy;
    int m_owner;
    int m_beat;
    int m_ptr;
    int m_err;

    // Producers: words still to send and the current word each presents.
    int         remaining [N];
    logic [7:0] val [N];
    logic [N-1:0] acked_last = '0;
    logic [N-1:0] prev_gnt = '0;
    logic [7:0] wr_log [$];
    int         gnt_log [$];

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_SIZE (DW),
        .MAX_BURST (MB),
        .ERR_CNT_W (EW)
    ) dut (
        .w_clk       (w_clk),
        .wrst_n      (wrst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .ack         (ack),
        .full        (full),
        .write_error (write_error),
        .w_en        (w_en),
        .data_in     (data_in),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return m_busy ? N'(1 << m_owner) : '0;
    endfunction

    function automatic logic exp_wen();
        return m_busy && req[m_owner] && !full;
    endfunction

    function automatic int first_from(input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model of grant ownership, burst length and rotation.
    always @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_beat  <= 0;
            m_ptr   <= 0;
            m_err   <= 0;
        end else begin
            if (write_error && m_err < ERR_MAX) m_err <= m_err + 1;
            if (!m_busy) begin
                if (first_from(m_ptr) >= 0) begin
                    m_busy  <= 1'b1;
                    m_owner <= first_from(m_ptr);
                    m_beat  <= 0;
                end
            end else if ((exp_wen() && m_beat == MB - 1) || !req[m_owner]) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_owner + 1) % N;
                m_beat <= 0;
            end else if (exp_wen()) begin
                m_beat <= m_beat + 1;
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle and log writes and new grants.
    always @(negedge w_clk) begin
        if (!wrst_n) begin
            acked_last = '0;
            prev_gnt   = '0;
        end else begin
            check("gnt", 32'(gnt), 32'(exp_gnt()));
            check("busy", 32'(busy), 32'(m_busy));
            check("w_en", 32'(w_en), 32'(exp_wen()));
            check("ack", 32'(ack), exp_wen() ? 32'(1 << m_owner) : 32'd0);
            check("err_count", 32'(err_count), 32'(m_err));
            if (m_busy) check("data_in", 32'(data_in), 32'(req_data[m_owner*DW +: DW]));
            if (w_en) wr_log.push_back(data_in);
            if (gnt != '0 && prev_gnt == '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
            end
            prev_gnt   = gnt;
            acked_last = ack;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (remaining[i] > 0);
            req_data[i*DW +: DW] = val[i];
        end
    endtask

    // Advance one cycle; producers step to their next word after an ack.
    task automatic step();
        @(posedge w_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acked_last[i] && remaining[i] > 0) begin
                val[i] = val[i] + 8'd1;
                remaining[i] = remaining[i] - 1;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        full = 1'b0;
        write_error = 1'b0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            val[i] = '0;
        end
        drive();
        step();
        step();
        wrst_n = 1'b1;
        wr_log.delete();
        gnt_log.delete();
    endtask

    initial begin
        int order [5];
        int base;
        int budget;
        order = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);

        // 1: single requester, 6 words -> burst of 4, dead cycle, burst of 2
        remaining[0] = 6;
        val[0] = 8'hA0;
        drive();
        step();
        check("t1_gnt_c1", 32'(gnt), 32'b0001);
        check("t1_wen_c1", 32'(w_en), 32'd1);
        repeat (14) step();
        check("t1_nwords", wr_log.size(), 6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            check("t1_word", 32'(wr_log[k]), 32'(8'hA0 + k));
        check("t1_ngrants", gnt_log.size(), 2);

        // 2: all requesting -> grants 0,1,2,3,0 of 4 words each
        do_reset();
        for (int i = 0; i < N; i++) begin
            remaining[i] = 100;
            val[i] = 8'(i * 8'h40);
        end
        drive();
        repeat (24) step();
        check("t2_ngrants", gnt_log.size(), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check("t2_order", gnt_log[k], order[k]);
        if (wr_log.size() >= 17) begin
            check("t2_w0", 32'(wr_log[0]), 32'h00);
            check("t2_w4", 32'(wr_log[4]), 32'h40);
            check("t2_w8", 32'(wr_log[8]), 32'h80);
            check("t2_w12", 32'(wr_log[12]), 32'hC0);
            check("t2_w16", 32'(wr_log[16]), 32'h04);
        end else begin
            check("t2_nwords", wr_log.size(), 17);
        end
        for (int i = 0; i < N; i++) remaining[i] = 0;
        drive();
        repeat (3) step();

        // 3: full stall after 2 words of requester 2
        do_reset();
        remaining[2] = 6;
        val[2] = 8'h30;
        drive();
        step();
        step();
        step();
        full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_gnt", 32'(gnt), 32'b0100);
            check("t3_stall_wen", 32'(w_en), 32'd0);
            step();
        end
        base = wr_log.size();
        check("t3_words_before", base, 2);
        full = 1'b0;
        budget = 20;
        while (gnt != '0 && budget > 0) begin
            step();
            budget--;
        end
        check("t3_end_timeout", 32'(budget > 0), 32'd1);
        check("t3_words_after", wr_log.size() - base, 2);
        remaining[2] = 0;
        drive();
        repeat (3) step();

        // 4: requester 1 forfeits after one word; requester 3 is next
        do_reset();
        remaining[1] = 1;
        val[1] = 8'h50;
        remaining[3] = 3;
        val[3] = 8'h70;
        drive();
        step();
        check("t4_gnt1", 32'(gnt), 32'b0010);
        step();
        step();
        check("t4_ptr", m_ptr, 2);
        check("t4_idle", 32'(gnt), 32'd0);
        step();
        check("t4_gnt3", 32'(gnt), 32'b1000);
        repeat (6) step();
        check("t4_grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) check("t4_second", gnt_log[1], 3);

        // 5: write_error saturation
        do_reset();
        for (int k = 0; k < 300; k++) begin
            write_error = 1'b1;
            step();
            write_error = 1'b0;
            step();
        end
        check("t5_err_sat", 32'(err_count), 32'd255);

        // 6: asynchronous reset mid-burst; arbitration restarts at index 0
        do_reset();
        write_error = 1'b1;
        repeat (3) step();
        write_error = 1'b0;
        remaining[0] = 1;
        val[0] = 8'h00;
        drive();
        repeat (4) step();
        remaining[1] = 10;
        val[1] = 8'h60;
        drive();
        step();
        step();
        step();
        check("t6_pre_gnt", 32'(gnt), 32'b0010);
        check("t6_pre_err", 32'(err_count), 32'd3);
        #2;
        wrst_n = 1'b0;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'd0);
        check("t6_async_wen", 32'(w_en), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_err", 32'(err_count), 32'd0);
        remaining[1] = 0;
        drive();
        step();
        step();
        wrst_n = 1'b1;
        remaining[0] = 2;
        val[0] = 8'h08;
        remaining[1] = 2;
        val[1] = 8'h68;
        drive();
        step();
        check("t6_restart", 32'(gnt), 32'b0001);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
